gf2_operand_loader: RTL
=======================

Name: gf2_operand_loader

Overview:
- Upstream stage of the GF(2) matrix-vector multiplier.
- Assembles matrix A, row by row, and operand B, column by column, from a narrow valid/ready beat stream.
- Presents both operands as flat buses with a valid/ready handshake, holding them stable until the multiplier side accepts.
- Detects framing errors using in_last and discards malformed frames.

Parameters:
- A_ROWS, 4, rows of A (and of the product C)
- A_COLS, 8, columns of A; equals rows of B; also the stream beat width
- B_COLS, 1, columns of B (and of C)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_data  in  A_COLS  one A row or one B column per beat
- in_valid  in  1  beat valid
- in_last  in  1  marks the final beat of a frame
- in_ready  out  1  loader can accept a beat
- A_data_out  out  A_ROWS*A_COLS  assembled A, row-major
- B_data_out  out  A_COLS*B_COLS  assembled B, row-major
- ops_valid  out  1  operands complete and stable
- ops_ready  in  1  downstream takes the operands
- frame_err  out  1  one-cycle pulse when a frame is discarded

Behaviour:
- Interface: one clock, clk; rst is synchronous and active-high.
- Reset: state LOAD_A; all counters 0. A_data_out, B_data_out, ops_valid and frame_err all read 0. in_ready is forced 0 while rst is high.
- Frame: A_ROWS + B_COLS beats. A rows 0..A_ROWS-1 arrive first, then B columns 0..B_COLS-1. in_last is set only on the final beat.
- A packing: beat r (A row r) is written to A_data_out[r*A_COLS +: A_COLS].
- B packing: beat for B column c scatters bit k of in_data to B_data_out[k*B_COLS + c], for k = 0..A_COLS-1.
- Handshake: a beat is accepted when in_valid && in_ready. Bubbles on in_valid are allowed anywhere.
- in_ready is decoded from state: 1 in LOAD_A and LOAD_B, 0 in HOLD.
- FSM, LOAD_A: row_cnt increments on each accepted beat. Accepting beat A_ROWS-1 moves to LOAD_B.
- FSM, LOAD_B: col_cnt increments on each accepted beat. Accepting beat B_COLS-1 with in_last=1 moves to HOLD.
- FSM, HOLD: ops_valid=1. When ops_ready=1, go to LOAD_A and clear the counters; ops_valid drops the next cycle.
- HOLD is the only state in which ops_valid=1.
- Latency: ops_valid rises the cycle after the final beat is accepted.
- Minimum frame period is A_ROWS + B_COLS + 1 cycles. The first beat of the next frame can be accepted the cycle after the ops_ready handshake.
- Stability: A_data_out and B_data_out do not change in HOLD. During LOAD states they update per beat and are meaningful only while ops_valid=1.
- Early-last error: in_last=1 on any accepted beat that is not the final beat.
  - The next cycle has frame_err=1 for exactly one cycle.
  - The FSM returns to LOAD_A with counters cleared; ops_valid stays 0.
  - The offending beat is consumed.
- Missing-last error: the final beat is accepted with in_last=0. The response is identical to the early-last case.
- Operand registers are not cleared on a frame error. Stale contents are overwritten by the next frame.
- Reset mid-frame or in HOLD: the frame is abandoned, all outputs go to their reset values, and no frame_err is raised.
- Degenerate parameters: A_ROWS >= 1, A_COLS >= 1, B_COLS >= 1. Counter widths are $clog2 of their limit, minimum 1 bit.
  - If A_ROWS=1 or B_COLS=1, the corresponding LOAD state lasts exactly one beat.

Decomposition:
- Shared package gf2_pkg holds:
  - the FSM state enum (LOAD_A, LOAD_B, HOLD);
  - default dimension constants, shared with the multiplier;
  - a function for the B column-to-row-major scatter index.
- No sub-module: the FSM, counters and packing registers form one block.
- The bench instantiates the loader feeding the multiplier (its A_data_in and B_data_in inputs) for end-to-end checks.

Test Plan:
All scenarios use default parameters (A_ROWS=4, A_COLS=8, B_COLS=1).
- Basic frame: beats 0x01, 0x02, 0x04, 0x08, then 0xFF with last, ops_ready=1 → one cycle after the last beat:
  - ops_valid=1, A_data_out=32'h08040201, B_data_out=8'hFF;
  - multiplier output one cycle later is 4'hF;
  - ops_valid low the following cycle.
- Backpressure with bubbles: the same frame with in_valid gaps of 0-3 cycles, ops_ready held low for 10 cycles after completion →
  - ops_valid stays 1 and the buses stay stable;
  - in_ready=0, and in_valid pulses during HOLD are ignored;
  - the handshake completes on the first cycle ops_ready=1.
- Early last: in_last=1 on beat 2 (0x02) → frame_err=1 for one cycle, no ops_valid. A following correct frame with A rows 0xAA×4 and B 0x0F gives A_data_out=32'hAAAAAAAA, B_data_out=8'h0F.
- Missing last: 5 beats with in_last=0 throughout → frame_err pulse after beat 5, no ops_valid, in_ready=1 the next cycle.
- Reset mid-frame: rst for 1 cycle after 2 accepted beats → all outputs 0, no frame_err. The next full frame behaves exactly as in the basic-frame scenario.
- Back-to-back frames: ops_ready tied to 1, two frames streamed with in_valid held high → second frame's first beat accepted the cycle after the HOLD handshake; two ops_valid pulses carrying the correct second-frame operands.

Source files
------------

// File: rtl/gf2_pkg.sv
// Shared definitions for the GF(2) matrix-vector datapath: loader FSM states,
// default operand dimensions and the B column-to-row-major index helper.
package gf2_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int unsigned GF2_A_ROWS = 4;
    localparam int unsigned GF2_A_COLS = 8;
    localparam int unsigned GF2_B_COLS = 1;

    // Bit k of B column c lives at row k, column c of a row-major B.
    function automatic int unsigned b_scatter_idx(input int unsigned k,
                                                  input int unsigned c,
                                                  input int unsigned b_cols);
        return k * b_cols + c;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/gf2_matvec_mul.sv
// GF(2) product C = A * B, registered on each operand handshake.
// Always ready; C holds its value between handshakes.
module gf2_matvec_mul
    import gf2_pkg::*;
#(
    parameter int unsigned A_ROWS = GF2_A_ROWS,
    parameter int unsigned A_COLS = GF2_A_COLS,
    parameter int unsigned B_COLS = GF2_B_COLS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [A_ROWS*A_COLS-1:0]   A_data_in,
    input  logic [A_COLS*B_COLS-1:0]   B_data_in,
    input  logic                       ops_valid,
    input  logic                       ops_ready,
    output logic [A_ROWS*B_COLS-1:0]   C_data_out,
    output logic                       C_valid
);

    logic [A_ROWS*B_COLS-1:0] c_q, c_d;
    logic                     c_valid_q, c_valid_d;

    always_comb begin
        logic acc;
        acc       = 1'b0;
        c_d       = c_q;
        c_valid_d = ops_valid && ops_ready;
        if (ops_valid && ops_ready) begin
            for (int i = 0; i < A_ROWS; i++) begin
                for (int j = 0; j < B_COLS; j++) begin
                    acc = 1'b0;
                    for (int k = 0; k < A_COLS; k++) begin
                        acc = acc ^ (A_data_in[i*A_COLS + k] &
                                     B_data_in[b_scatter_idx(k, j, B_COLS)]);
                    end
                    c_d[i*B_COLS + j] = acc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q       <= '0;
            c_valid_q <= 1'b0;
        end else begin
            c_q       <= c_d;
            c_valid_q <= c_valid_d;
        end
    end

    assign C_data_out = c_q;
    assign C_valid    = c_valid_q;

endmodule

// File: rtl/gf2_operand_loader.sv
// Assembles A (row per beat) then B (column per beat) from a beat stream and
// presents them as stable flat operands; malformed frames are dropped with frame_err.
module gf2_operand_loader
    import gf2_pkg::*;
#(
    parameter int unsigned A_ROWS = GF2_A_ROWS,
    parameter int unsigned A_COLS = GF2_A_COLS,
    parameter int unsigned B_COLS = GF2_B_COLS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [A_COLS-1:0]          in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [A_ROWS*A_COLS-1:0]   A_data_out,
    output logic [A_COLS*B_COLS-1:0]   B_data_out,
    output logic                       ops_valid,
    input  logic                       ops_ready,
    output logic                       frame_err
);

    localparam int unsigned ROW_W = cnt_width(A_ROWS);
    localparam int unsigned COL_W = cnt_width(B_COLS);

    state_t                   state_q, state_d;
    logic [ROW_W-1:0]         row_cnt_q, row_cnt_d;
    logic [COL_W-1:0]         col_cnt_q, col_cnt_d;
    logic [A_ROWS*A_COLS-1:0] a_q, a_d;
    logic [A_COLS*B_COLS-1:0] b_q, b_d;
    logic                     ops_valid_q, ops_valid_d;
    logic                     frame_err_q, frame_err_d;
    logic                     accept;
    logic                     abort;
    logic                     last_row;
    logic                     last_col;

    assign in_ready = (state_q != HOLD) && !rst;
    assign accept   = in_valid && in_ready;
    assign last_row = (row_cnt_q == ROW_W'(A_ROWS - 1));
    assign last_col = (col_cnt_q == COL_W'(B_COLS - 1));

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        col_cnt_d   = col_cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        frame_err_d = 1'b0;
        abort       = 1'b0;

        case (state_q)
            LOAD_A: begin
                if (accept) begin
                    for (int r = 0; r < A_ROWS; r++) begin
                        if (ROW_W'(r) == row_cnt_q) begin
                            a_d[r*A_COLS +: A_COLS] = in_data;
                        end
                    end
                    // B always follows A, so no A beat may carry in_last.
                    if (in_last) begin
                        abort = 1'b1;
                    end else if (last_row) begin
                        state_d   = LOAD_B;
                        row_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    for (int k = 0; k < A_COLS; k++) begin
                        for (int c = 0; c < B_COLS; c++) begin
                            if (COL_W'(c) == col_cnt_q) begin
                                b_d[b_scatter_idx(k, c, B_COLS)] = in_data[k];
                            end
                        end
                    end
                    // Covers both early-last and missing-last framing errors.
                    if (in_last != last_col) begin
                        abort = 1'b1;
                    end else if (last_col) begin
                        state_d   = HOLD;
                        col_cnt_d = '0;
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (ops_ready) begin
                    state_d   = LOAD_A;
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                end
            end
            default: begin
                state_d   = LOAD_A;
                row_cnt_d = '0;
                col_cnt_d = '0;
            end
        endcase

        if (abort) begin
            state_d     = LOAD_A;
            row_cnt_d   = '0;
            col_cnt_d   = '0;
            frame_err_d = 1'b1;
        end

        ops_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD_A;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ops_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            col_cnt_q   <= col_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ops_valid_q <= ops_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign A_data_out = a_q;
    assign B_data_out = b_q;
    assign ops_valid  = ops_valid_q;
    assign frame_err  = frame_err_q;

endmodule
